// File: rtl/interconn_arb_if.sv
// Send/receive bundle for the arbitrated MVU crossbar; flat buses, slot i at [i*width +: width].
interface interconn_arb_if #(
  parameter int N = 32,
  parameter int W = 96
);
  localparam int A = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]   sendValid;
  logic [N*A-1:0] sendAddr;
  logic [N*W-1:0] sendMsg;
  logic [N-1:0]   sendReady;
  logic [N-1:0]   recvValid;
  logic [N*W-1:0] recvMsg;
  logic [N*A-1:0] recvSrc;
  logic [N-1:0]   recvReady;
  logic           err;

  modport master (
    output sendValid, sendAddr, sendMsg, recvReady,
    input  sendReady, recvValid, recvMsg, recvSrc, err
  );

  modport slave (
    input  sendValid, sendAddr, sendMsg, recvReady,
    output sendReady, recvValid, recvMsg, recvSrc, err
  );
endinterface

// File: rtl/interconn_arb.sv
// Registered crossbar: per-destination round-robin arbiter feeding a one-deep
// valid/ready output register; out-of-range destinations are swallowed and flagged.
module interconn_arb #(
  parameter int n = 32,
  parameter int w = 96
) (
  input  logic            clk,
  input  logic            rst,
  interconn_arb_if.slave  bus
);
  localparam int a = (n > 1) ? $clog2(n) : 1;

  logic [n-1:0]          sv, rready, oor, rdy, gv;
  logic [n-1:0][a-1:0]   addr, gi;
  logic [n-1:0][w-1:0]   smsg;

  logic [n-1:0]          vld_q;
  logic [n-1:0][w-1:0]   msg_q;
  logic [n-1:0][a-1:0]   src_q, rr_q;
  logic                  err_q, err_d;

  assign sv     = bus.sendValid;
  assign addr   = bus.sendAddr;
  assign smsg   = bus.sendMsg;
  assign rready = bus.recvReady;

  logic          found;
  int            idx;
  logic [a-1:0]  ix;

  always_comb begin
    gv    = '0;
    gi    = '0;
    oor   = '0;
    rdy   = '0;
    found = 1'b0;
    idx   = 0;
    ix    = '0;
    for (int i = 0; i < n; i++) begin
      oor[i] = sv[i] && (32'(addr[i]) >= 32'(n));
      rdy[i] = oor[i];
    end
    for (int d = 0; d < n; d++) begin
      found = 1'b0;
      for (int k = 0; k < n; k++) begin
        idx = int'(rr_q[d]) + k;
        if (idx >= n) idx = idx - n;
        ix = a'(idx);
        if (!found && sv[ix] && addr[ix] == a'(d)) begin
          found = 1'b1;
          gi[d] = ix;
        end
      end
      // a full, unconsumed slot blocks the grant so the held message stays frozen
      gv[d] = found && (!vld_q[d] || rready[d]);
      if (gv[d]) rdy[gi[d]] = 1'b1;
    end
    if (rst) rdy = '0;
  end

  assign err_d = err_q | (|oor);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      msg_q <= '0;
      src_q <= '0;
      rr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
      for (int d = 0; d < n; d++) begin
        if (gv[d]) begin
          vld_q[d] <= 1'b1;
          msg_q[d] <= smsg[gi[d]];
          src_q[d] <= gi[d];
          rr_q[d]  <= (gi[d] == a'(n - 1)) ? '0 : gi[d] + 1'b1;
        end else if (rready[d]) begin
          vld_q[d] <= 1'b0;
        end
      end
    end
  end

  assign bus.sendReady = rdy;
  assign bus.recvValid = vld_q;
  assign bus.recvMsg   = msg_q;
  assign bus.recvSrc   = src_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_interconn_arb.sv
// Bench for interconn_arb: vector table with per-destination scoreboard (n=4),
// plus hand sequences for out-of-range and mid-operation reset (n=3).
module tb_interconn_arb;
  logic clk, rst4, rst3;
  int   checks = 0;
  int   errors = 0;

  interconn_arb_if #(.N(4), .W(16)) b4 ();
  interconn_arb_if #(.N(3), .W(16)) b3 ();

  interconn_arb #(.n(4), .w(16)) u4 (.clk(clk), .rst(rst4), .bus(b4));
  interconn_arb #(.n(3), .w(16)) u3 (.clk(clk), .rst(rst3), .bus(b3));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [3:0]  v;
    logic [7:0]  ad;
    logic [63:0] m;
    logic [3:0]  rd;
    logic [3:0]  ex;
  } vec_t;

  typedef struct {
    logic [15:0] m;
    logic [1:0]  s;
  } exp_t;

  vec_t tbl[$];
  exp_t sb4 [4][$];

  function automatic vec_t mk(input logic [3:0] v, input logic [7:0] ad,
                              input logic [63:0] m, input logic [3:0] rd,
                              input logic [3:0] ex);
    vec_t r;
    r.v = v; r.ad = ad; r.m = m; r.rd = rd; r.ex = ex;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Drive one vector, check sendReady and consumed outputs before the edge,
  // then check the output registers after it.
  task automatic step4(input int n, input vec_t t);
    exp_t e;
    logic [1:0] dst;
    b4.sendValid = t.v;
    b4.sendAddr  = t.ad;
    b4.sendMsg   = t.m;
    b4.recvReady = t.rd;
    #4;
    chk($sformatf("v%0d sendReady", n), b4.sendReady, t.ex);
    for (int d = 0; d < 4; d++) begin
      if (b4.recvValid[d] && t.rd[d]) begin
        if (sb4[d].size() == 0) begin
          chk($sformatf("v%0d unexpected consume d%0d", n, d), 1'b1, 1'b0);
        end else begin
          e = sb4[d].pop_front();
          chk($sformatf("v%0d msg d%0d", n, d), b4.recvMsg[d*16 +: 16], e.m);
          chk($sformatf("v%0d src d%0d", n, d), b4.recvSrc[d*2 +: 2], e.s);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (t.ex[i]) begin
        dst = t.ad[i*2 +: 2];
        e.m = t.m[i*16 +: 16];
        e.s = 2'(i);
        sb4[dst].push_back(e);
      end
    end
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("v%0d post vld d%0d", n, d), b4.recvValid[d], sb4[d].size() != 0);
      if (sb4[d].size() != 0) begin
        chk($sformatf("v%0d post msg d%0d", n, d), b4.recvMsg[d*16 +: 16], sb4[d][0].m);
        chk($sformatf("v%0d post src d%0d", n, d), b4.recvSrc[d*2 +: 2], sb4[d][0].s);
      end
    end
  endtask

  initial begin
    // idle
    tbl.push_back(mk(4'h0, 8'h00, 64'h0, 4'hF, 4'h0));
    // single transfer: sender 1 -> dest 2
    tbl.push_back(mk(4'b0010, 8'h08, 64'h0000_0000_DEAD_0000, 4'hF, 4'b0010));
    tbl.push_back(mk(4'h0, 8'h00, 64'h0, 4'hF, 4'h0));
    // permutation 0->3, 1->2, 2->1, 3->0
    tbl.push_back(mk(4'hF, 8'h1B, 64'hA3A3_A2A2_A1A1_A0A0, 4'hF, 4'hF));
    tbl.push_back(mk(4'h0, 8'h00, 64'h0, 4'hF, 4'h0));
    // two destinations with two requesters each
    tbl.push_back(mk(4'hF, 8'hA5, 64'h3333_2222_1111_0000, 4'hF, 4'b0101));
    tbl.push_back(mk(4'b1010, 8'hA5, 64'h3333_2222_1111_0000, 4'hF, 4'b1010));
    tbl.push_back(mk(4'h0, 8'h00, 64'h0, 4'hF, 4'h0));
    // contention on dest 0 from senders 0,1,3: grants rotate 0,1,3,0,1,3
    for (int r = 0; r < 2; r++) begin
      tbl.push_back(mk(4'b1011, 8'h00, 64'hC003_0000_C001_C000, 4'hF, 4'b0001));
      tbl.push_back(mk(4'b1011, 8'h00, 64'hC003_0000_C001_C000, 4'hF, 4'b0010));
      tbl.push_back(mk(4'b1011, 8'h00, 64'hC003_0000_C001_C000, 4'hF, 4'b1000));
    end
    tbl.push_back(mk(4'h0, 8'h00, 64'h0, 4'hF, 4'h0));
    // backpressure on dest 2
    tbl.push_back(mk(4'b0010, 8'h08, 64'h0000_0000_BEEF_0000, 4'hF, 4'b0010));
    for (int r = 0; r < 5; r++)
      tbl.push_back(mk(4'b0001, 8'h02, 64'h0000_0000_0000_1234, 4'b1011, 4'h0));
    tbl.push_back(mk(4'b0001, 8'h02, 64'h0000_0000_0000_1234, 4'hF, 4'b0001));
    tbl.push_back(mk(4'h0, 8'h00, 64'h0, 4'hF, 4'h0));

    // reset with random inputs
    rst4 = 1'b1;
    rst3 = 1'b1;
    b4.sendValid = 4'($urandom); b4.sendAddr = 8'($urandom);
    b4.sendMsg = {$urandom, $urandom}; b4.recvReady = 4'($urandom);
    b3.sendValid = 3'($urandom); b3.sendAddr = 6'($urandom);
    b3.sendMsg = 48'({$urandom, $urandom}); b3.recvReady = 3'($urandom);
    @(posedge clk);
    #1;
    chk("rst sendReady", b4.sendReady, 4'h0);
    chk("rst recvValid", b4.recvValid, 4'h0);
    chk("rst recvMsg", b4.recvMsg, 64'h0);
    chk("rst recvSrc", b4.recvSrc, 8'h0);
    chk("rst err", b4.err, 1'b0);
    chk("rst3 sendReady", b3.sendReady, 3'h0);
    chk("rst3 err", b3.err, 1'b0);
    b4.sendValid = '0; b4.sendAddr = '0; b4.sendMsg = '0; b4.recvReady = '0;
    b3.sendValid = '0; b3.sendAddr = '0; b3.sendMsg = '0; b3.recvReady = '0;
    rst4 = 1'b0;
    rst3 = 1'b0;
    @(posedge clk);
    #1;
    chk("post-rst recvMsg", b4.recvMsg, 64'h0);
    chk("post-rst err", b4.err, 1'b0);

    for (int k = 0; k < tbl.size(); k++) step4(k, tbl[k]);
    chk("n4 err stays 0", b4.err, 1'b0);

    // n=3: out-of-range address 3 is accepted and dropped
    b3.sendValid = 3'b001; b3.sendAddr = 6'b00_00_11; b3.sendMsg = 48'h77;
    b3.recvReady = 3'b111;
    #4;
    chk("oor sendReady", b3.sendReady, 3'b001);
    @(posedge clk);
    #1;
    chk("oor recvValid", b3.recvValid, 3'b000);
    chk("oor err", b3.err, 1'b1);
    b3.sendValid = 3'b000;
    @(posedge clk);
    #1;
    chk("oor err sticky", b3.err, 1'b1);

    // fill all three outputs: 0->2, 1->0, 2->1
    b3.sendValid = 3'b111; b3.sendAddr = 6'b01_00_10;
    b3.sendMsg = 48'h0033_0022_0011; b3.recvReady = 3'b000;
    #4;
    chk("fill sendReady", b3.sendReady, 3'b111);
    @(posedge clk);
    #1;
    chk("fill recvValid", b3.recvValid, 3'b111);
    chk("fill recvMsg", b3.recvMsg, 48'h0011_0033_0022);
    chk("fill recvSrc", b3.recvSrc, 6'b00_10_01);
    b3.sendValid = 3'b001; b3.sendAddr = 6'b00_00_00; b3.sendMsg = 48'h55;
    #1;
    chk("full sendReady", b3.sendReady, 3'b000);
    // asynchronous reset mid-cycle
    #1;
    rst3 = 1'b1;
    #1;
    chk("midrst recvValid", b3.recvValid, 3'b000);
    chk("midrst recvMsg", b3.recvMsg, 48'h0);
    chk("midrst recvSrc", b3.recvSrc, 6'h0);
    chk("midrst err", b3.err, 1'b0);
    chk("midrst sendReady", b3.sendReady, 3'b000);
    @(posedge clk);
    #1;
    rst3 = 1'b0;
    b3.sendValid = 3'b000;
    @(posedge clk);
    #1;
    chk("after rst3 recvValid", b3.recvValid, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
